// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Misses stall the pipeline while whole 4-word lines move over a req/ack memory port.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ack
);
  localparam int TAG_BITS = 28 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_next;

  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [127:0]        data_arr [LINES];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] idx;
  logic [1:0]            offset;
  logic [127:0]          line;
  logic [127:0]          merged;
  logic                  hit;
  logic                  ack;
  logic                  fill;
  logic                  store_hit;
  logic                  addr_unused;

  assign req_tag     = cpu_addr[31:4+INDEX_BITS];
  assign idx         = cpu_addr[3+INDEX_BITS:4];
  assign offset      = cpu_addr[3:2];
  assign addr_unused = ^cpu_addr[1:0];

  assign line      = data_arr[idx];
  assign hit       = cpu_req & valid[idx] & (tag_arr[idx] == req_tag);
  // An ack only counts while a transaction is actually outstanding.
  assign ack       = mem_ack & mem_req;
  assign fill      = (state == ALLOCATE) & ack;
  assign store_hit = (state == IDLE) & hit & cpu_we;

  assign cpu_rdata = line[{offset, 5'b0} +: 32];

  always_comb begin
    merged = line;
    merged[{offset, 5'b0} +: 32] = cpu_wdata;
  end

  // Victim address during write-back, requested line otherwise; both stay
  // stable for the whole transaction because the CPU holds its request.
  assign mem_addr  = (state == WRITEBACK) ? {tag_arr[idx], idx, 4'b0}
                                          : {req_tag, idx, 4'b0};
  assign mem_wdata = line;

  always_comb begin
    state_next = state;
    cpu_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && !hit) begin
          cpu_stall  = 1'b1;
          state_next = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cpu_stall = 1'b1;
        if (ack) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall = 1'b1;
        if (ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      valid   <= '0;
      dirty   <= '0;
    end else begin
      state   <= state_next;
      mem_req <= (state_next != IDLE);
      mem_we  <= (state_next == WRITEBACK);
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_arr[idx]  <= req_tag;
      data_arr[idx] <= mem_rdata;
    end else if (store_hit) begin
      data_arr[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: vector table of CPU accesses against a
// latency-configurable memory model, plus reset and spurious-ack sequences.
module tb_dcache_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         cpu_stall;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ack;

  dcache_ctrl #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    int           lat;
    logic [31:0]  rdata;
    int           stall;
    logic         wb;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
  } vec_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } wb_t;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 2;
  logic spurious = 1'b0;

  logic [127:0] mem [logic [31:0]];
  wb_t          exp_wb_q [$];
  logic [31:0]  rd_q [$];
  vec_t         vecs [13];

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [127:0] line_of(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a + 32'd3, a + 32'd2, a + 32'd1, a};
  endfunction

  // Memory: acks after lat cycles of mem_req, checks request stability.
  initial begin
    int           cnt;
    logic         snap_we;
    logic [31:0]  snap_addr;
    logic [127:0] snap_wdata;
    wb_t          w;
    cnt = 0; snap_we = 1'b0; snap_addr = '0; snap_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end
      if (spurious) begin
        spurious = 1'b0;
        mem_ack = 1'b1;
      end else if (mem_req) begin
        cnt++;
        if (cnt == 1) begin
          snap_we = mem_we; snap_addr = mem_addr; snap_wdata = mem_wdata;
        end else begin
          check("mem_we_stable", mem_we, snap_we);
          check("mem_addr_stable", mem_addr, snap_addr);
          if (snap_we) check("mem_wdata_stable", mem_wdata, snap_wdata);
        end
        if (cnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            check("wb_expected", exp_wb_q.size() > 0, 1'b1);
            if (exp_wb_q.size() > 0) begin
              w = exp_wb_q.pop_front();
              check("wb_addr", mem_addr, w.addr);
              check("wb_data", mem_wdata, w.data);
            end
            mem[mem_addr] = mem_wdata;
          end else begin
            check("fill_addr", mem_addr, {cpu_addr[31:4], 4'b0});
            mem_rdata = line_of(mem_addr);
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input int exp_stall, input string name);
    int stalls;
    logic [31:0] exp;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    if (!we) rd_q.push_back(exp_rd);
    stalls = 0;
    #1;
    while (cpu_stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check({"stall_", name}, stalls, exp_stall);
    if (!we) begin
      exp = rd_q.pop_front();
      check({"rdata_", name}, cpu_rdata, exp);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    mem[32'h40] = {32'd4, 32'd3, 32'd2, 32'd1};
    //         we    addr          wdata          lat rdata          stall wb    wb_addr     wb_data
    vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,        2, 32'd1,         3, 1'b0, 32'h0,   128'h0};
    vecs[1]  = '{1'b0, 32'h0000_0048, 32'h0,        2, 32'd3,         0, 1'b0, 32'h0,   128'h0};
    vecs[2]  = '{1'b1, 32'h0000_0044, 32'hDEADBEEF, 2, 32'h0,         0, 1'b0, 32'h0,   128'h0};
    vecs[3]  = '{1'b0, 32'h0000_0044, 32'h0,        2, 32'hDEADBEEF,  0, 1'b0, 32'h0,   128'h0};
    vecs[4]  = '{1'b0, 32'h0000_0140, 32'h0,        2, 32'h140,       5, 1'b1, 32'h40,
                 {32'd4, 32'd3, 32'hDEADBEEF, 32'd1}};
    vecs[5]  = '{1'b1, 32'h0000_0200, 32'h55,       2, 32'h0,         3, 1'b0, 32'h0,   128'h0};
    vecs[6]  = '{1'b0, 32'h0000_0200, 32'h0,        2, 32'h55,        0, 1'b0, 32'h0,   128'h0};
    vecs[7]  = '{1'b0, 32'h0000_020C, 32'h0,        2, 32'h203,       0, 1'b0, 32'h0,   128'h0};
    vecs[8]  = '{1'b0, 32'h0000_1200, 32'h0,        7, 32'h1200,     15, 1'b1, 32'h200,
                 {32'h203, 32'h202, 32'h201, 32'h55}};
    vecs[9]  = '{1'b0, 32'h0000_0048, 32'h0,        2, 32'd3,         3, 1'b0, 32'h0,   128'h0};
    vecs[10] = '{1'b0, 32'h0000_0044, 32'h0,        2, 32'hDEADBEEF,  0, 1'b0, 32'h0,   128'h0};
    vecs[11] = '{1'b1, 32'h0000_014C, 32'h77,       2, 32'h0,         3, 1'b0, 32'h0,   128'h0};
    vecs[12] = '{1'b0, 32'h0000_014C, 32'h0,        2, 32'h77,        0, 1'b0, 32'h0,   128'h0};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_mem_we", mem_we, 1'b0);
    check("reset_stall_idle", cpu_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 32'h44;
    #1;
    check("reset_all_miss", cpu_stall, 1'b1);
    cpu_req = 1'b0;
    #1;
    check("no_req_no_stall", cpu_stall, 1'b0);

    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      if (vecs[i].wb) exp_wb_q.push_back('{vecs[i].wb_addr, vecs[i].wb_data});
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].stall,
             $sformatf("v%0d", i));
      check($sformatf("wb_consumed_v%0d", i), exp_wb_q.size(), 0);
    end

    // Spurious ack while idle must not disturb anything.
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("spurious_mem_req", mem_req, 1'b0);
    access(1'b0, 32'h14C, 32'h0, 32'h77, 0, "after_spurious");

    // Reset in the middle of ALLOCATE abandons the fill and dirty data.
    lat = 20;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    repeat (4) @(negedge clk);
    #1;
    check("alloc_mem_req", mem_req, 1'b1);
    check("alloc_mem_we", mem_we, 1'b0);
    check("alloc_mem_addr", mem_addr, 32'h300);
    check("alloc_stall", cpu_stall, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_mem_req", mem_req, 1'b0);
    check("rst_mid_mem_we", mem_we, 1'b0);
    cpu_req = 1'b0;
    #1;
    check("rst_mid_stall", cpu_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("late_ack_mem_req", mem_req, 1'b0);
    lat = 2;
    access(1'b0, 32'h14C, 32'h0, 32'h143, 3, "post_rst_dirty_lost");
    access(1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 3, "post_rst_miss_44");
    check("wb_queue_empty", exp_wb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller.
- Sits between the MEM stage and main memory, and returns load data for the MEM/WB pipeline register.
- Asserts cpu_stall on a miss; the pipeline freezes every stage register while cpu_stall is high.
- Moves whole 4-word lines to and from memory over a req/ack handshake.

Parameters:
- INDEX_BITS, 4, number of index bits; the cache has 2**INDEX_BITS lines.
- TAG_BITS, 28-INDEX_BITS, tag width (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  MEM stage has a load or store this cycle.
- cpu_we  in  1  1 = store, 0 = load; valid only when cpu_req is high.
- cpu_addr  in  32  byte address; [1:0] ignored, [3:2] word offset, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; combinational on a hit.
- cpu_stall  out  1  freeze pipeline; combinational.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = line write-back, 0 = line fill.
- mem_addr  out  32  line-aligned address; [3:0] = 0.
- mem_wdata  out  128  victim line; word 0 in [31:0].
- mem_rdata  in  128  fill line; same word order as mem_wdata.
- mem_ack  in  1  one-cycle pulse: transaction complete; fill data is valid in the same cycle.

Behaviour:
- Storage per line: valid bit, dirty bit, tag, 4x32 data.
- FSM states: IDLE, WRITEBACK, ALLOCATE.

IDLE
- hit = cpu_req & valid[idx] & (tag[idx] == addr tag).
- Hit load: cpu_rdata = selected word the same cycle; cpu_stall = 0; zero added latency.
- Hit store: at posedge, write cpu_wdata into the word and set dirty = 1; cpu_stall = 0.
- Miss (cpu_req & !hit): cpu_stall = 1 combinationally in the same cycle.
  - Next state is WRITEBACK if the victim is valid & dirty, else ALLOCATE.
- cpu_req = 0: no state change; cpu_stall = 0.

WRITEBACK
- Drive mem_req = 1, mem_we = 1, mem_addr = {victim tag, idx, 4'b0}, mem_wdata = victim line.
- Hold all of these stable until mem_ack; on mem_ack go to ALLOCATE.

ALLOCATE
- Drive mem_req = 1, mem_we = 0, mem_addr = {cpu tag, idx, 4'b0}.
- On mem_ack: write mem_rdata into the line, set valid = 1, dirty = 0, tag = cpu tag; go to IDLE.

Stall and outputs
- cpu_stall = 1 in every cycle spent in WRITEBACK or ALLOCATE.
- After returning to IDLE, the held request re-evaluates as a hit. A store is merged at that posedge and the line becomes dirty.
- Miss cost: clean = ack latency + 1 cycle; dirty = two ack latencies + 1 cycle.
- mem_req is registered; it is never asserted in IDLE.
- mem_req deasserts in the cycle after the final mem_ack.
- mem_ack while mem_req = 0 is ignored.
- The CPU holds cpu_req, cpu_we, cpu_addr and cpu_wdata stable while cpu_stall = 1.
- cpu_rdata when not a hit load: drive the selected word of the indexed line (don't-care, but no X from an invalid index).

Reset
- Asynchronous; takes effect regardless of state.
- All valid and dirty bits = 0, state = IDLE, mem_req = 0, mem_we = 0.
- Data and tag arrays are not reset.
- Reset during WRITEBACK or ALLOCATE abandons the transaction. Dirty data is lost, and any later mem_ack is ignored.
- Immediately after reset every request misses.

Test Plan:
- Reset, then load from 0x0000_0040 with memory line {D,C,B,A} = {4,3,2,1}: cpu_stall high until ack. Next cycle cpu_rdata = 1 and cpu_stall = 0. Load from 0x0000_0048 hits immediately with cpu_rdata = 3.
- Store 0xDEAD_BEEF to 0x0000_0044 (hit): no stall. Following load from 0x44 returns 0xDEAD_BEEF, and the line is marked dirty.
- Load from 0x0000_0140 (same index 4, different tag) with the dirty line present: WRITEBACK issues mem_addr = 0x0000_0040, mem_we = 1, mem_wdata = {4,3,0xDEADBEEF,1}. ALLOCATE then issues mem_addr = 0x0000_0140, mem_we = 0. Stall lasts two ack latencies + 1 cycle.
- Store miss to a clean index, 0x0000_0200 with data 0x55: only ALLOCATE occurs (no write-back). After fill the word reads 0x55 and the line is dirty.
- Memory ack delayed 7 cycles: mem_req, mem_we and mem_addr stay constant for all 7 cycles. A spurious mem_ack pulse in IDLE changes nothing.
- Assert rst in the middle of ALLOCATE: mem_req = 0 and state = IDLE immediately. The previously cached 0x44 now misses, and a late mem_ack is ignored.
